// File: rtl/uart_ad_rx.sv
// 8N1 UART receiver (16x oversampled) feeding a decoder for "ADn:+d.dddV" voltage records.
// Recovers channel, sign and four BCD digits per record; malformed records raise parse_err.
module uart_ad_rx #(
    parameter int BAUD_DIV = 326
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        rx,
    output logic [7:0]  byte_data,
    output logic        byte_valid,
    output logic        frame_err,
    output logic        rec_valid,
    output logic        rec_ch,
    output logic        rec_neg,
    output logic [15:0] rec_bcd,
    output logic        parse_err
);
    localparam int            CW        = $clog2(BAUD_DIV);
    localparam logic [CW-1:0] TICK_LAST = CW'(BAUD_DIV - 1);

    typedef enum logic [1:0] {B_IDLE, B_START, B_DATA, B_STOP} byte_state_e;

    // Declaration order is the expected character order of a record.
    typedef enum logic [3:0] {
        R_HUNT, R_D, R_CH, R_COLON, R_SIGN, R_D0, R_DOT, R_D1, R_D2, R_D3, R_V
    } rec_state_e;

    logic          rx_meta_q, rx_sync_q, rx_prev_q;
    logic [CW-1:0] tick_cnt_q, tick_cnt_d;
    logic          tick, start_edge;

    byte_state_e   byte_state_q;
    logic [3:0]    os_cnt_q;
    logic [2:0]    bit_cnt_q;
    logic [7:0]    shift_q;
    logic [7:0]    byte_data_q;
    logic          byte_valid_q, frame_err_q;

    rec_state_e    rec_state_q;
    logic          byte_ok;
    logic          ch_q, neg_q;
    logic [15:0]   bcd_q;
    logic          rec_valid_q, rec_ch_q, rec_neg_q, parse_err_q;
    logic [15:0]   rec_bcd_q;

    assign tick       = (tick_cnt_q == TICK_LAST);
    assign start_edge = (byte_state_q == B_IDLE) && rx_prev_q && !rx_sync_q;

    always_comb begin
        tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
        if (start_edge) begin
            tick_cnt_d = '0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register samples
    // the pre-edge values of the others regardless of statement order.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rx_meta_q  <= 1'b1;
            rx_sync_q  <= 1'b1;
            rx_prev_q  <= 1'b1;
            tick_cnt_q <= '0;
        end else begin
            rx_meta_q  <= rx;
            rx_sync_q  <= rx_meta_q;
            rx_prev_q  <= rx_sync_q;
            tick_cnt_q <= tick_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            byte_state_q <= B_IDLE;
            os_cnt_q     <= '0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            byte_data_q  <= '0;
            byte_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            byte_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            case (byte_state_q)
                B_IDLE: begin
                    if (start_edge) begin
                        byte_state_q <= B_START;
                        os_cnt_q     <= '0;
                    end
                end
                B_START: begin
                    if (tick) begin
                        if (os_cnt_q == 4'd7) begin
                            os_cnt_q     <= '0;
                            bit_cnt_q    <= '0;
                            byte_state_q <= rx_sync_q ? B_IDLE : B_DATA;
                        end else begin
                            os_cnt_q <= os_cnt_q + 4'd1;
                        end
                    end
                end
                B_DATA: begin
                    if (tick) begin
                        if (os_cnt_q == 4'd15) begin
                            os_cnt_q  <= '0;
                            shift_q   <= {rx_sync_q, shift_q[7:1]};
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                            if (bit_cnt_q == 3'd7) begin
                                byte_state_q <= B_STOP;
                            end
                        end else begin
                            os_cnt_q <= os_cnt_q + 4'd1;
                        end
                    end
                end
                B_STOP: begin
                    if (tick) begin
                        if (os_cnt_q == 4'd15) begin
                            os_cnt_q     <= '0;
                            byte_state_q <= B_IDLE;
                            if (rx_sync_q) begin
                                byte_data_q  <= shift_q;
                                byte_valid_q <= 1'b1;
                            end else begin
                                frame_err_q <= 1'b1;
                            end
                        end else begin
                            os_cnt_q <= os_cnt_q + 4'd1;
                        end
                    end
                end
                default: byte_state_q <= B_IDLE;
            endcase
        end
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        byte_ok = 1'b0;
        case (rec_state_q)
            R_HUNT:                  byte_ok = (byte_data_q == "A");
            R_D:                     byte_ok = (byte_data_q == "D");
            R_CH:                    byte_ok = (byte_data_q == "1") || (byte_data_q == "2");
            R_COLON:                 byte_ok = (byte_data_q == ":");
            R_SIGN:                  byte_ok = (byte_data_q == "+") || (byte_data_q == "-");
            R_D0, R_D1, R_D2, R_D3:  byte_ok = (byte_data_q >= "0") && (byte_data_q <= "9");
            R_DOT:                   byte_ok = (byte_data_q == ".");
            R_V:                     byte_ok = (byte_data_q == "V");
            default:                 byte_ok = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rec_state_q <= R_HUNT;
            ch_q        <= 1'b0;
            neg_q       <= 1'b0;
            bcd_q       <= '0;
            rec_valid_q <= 1'b0;
            rec_ch_q    <= 1'b0;
            rec_neg_q   <= 1'b0;
            rec_bcd_q   <= '0;
            parse_err_q <= 1'b0;
        end else begin
            rec_valid_q <= 1'b0;
            parse_err_q <= 1'b0;
            if (frame_err_q) begin
                if (rec_state_q != R_HUNT) begin
                    parse_err_q <= 1'b1;
                end
                rec_state_q <= R_HUNT;
            end else if (byte_valid_q) begin
                if (byte_ok) begin
                    // For '0'..'9' the low nibble already equals the character minus 48.
                    case (rec_state_q)
                        R_CH:    ch_q          <= byte_data_q[1];
                        R_SIGN:  neg_q         <= (byte_data_q == "-");
                        R_D0:    bcd_q[15:12]  <= byte_data_q[3:0];
                        R_D1:    bcd_q[11:8]   <= byte_data_q[3:0];
                        R_D2:    bcd_q[7:4]    <= byte_data_q[3:0];
                        R_D3:    bcd_q[3:0]    <= byte_data_q[3:0];
                        default: ;
                    endcase
                    if (rec_state_q == R_V) begin
                        rec_valid_q <= 1'b1;
                        rec_ch_q    <= ch_q;
                        rec_neg_q   <= neg_q;
                        rec_bcd_q   <= bcd_q;
                        rec_state_q <= R_HUNT;
                    end else begin
                        rec_state_q <= rec_state_e'(rec_state_q + 4'd1);
                    end
                end else if (rec_state_q != R_HUNT) begin
                    parse_err_q <= 1'b1;
                    rec_state_q <= (byte_data_q == "A") ? R_D : R_HUNT;
                end
            end
        end
    end

    assign byte_data  = byte_data_q;
    assign byte_valid = byte_valid_q;
    assign frame_err  = frame_err_q;
    assign rec_valid  = rec_valid_q;
    assign rec_ch     = rec_ch_q;
    assign rec_neg    = rec_neg_q;
    assign rec_bcd    = rec_bcd_q;
    assign parse_err  = parse_err_q;

endmodule

// File: tb/tb_uart_ad_rx.sv
// Bench for uart_ad_rx: serial stimulus against a template-matching record model,
// compared every cycle, plus literal expectations for the directed sequences.
module tb_uart_ad_rx;
    localparam int BAUD_DIV = 4;
    localparam int BIT_CLKS = 16 * BAUD_DIV;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        rx = 1'b1;
    logic [7:0]  byte_data;
    logic        byte_valid, frame_err, rec_valid, rec_ch, rec_neg, parse_err;
    logic [15:0] rec_bcd;

    always #5 clk = ~clk;

    uart_ad_rx #(.BAUD_DIV(BAUD_DIV)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .rx         (rx),
        .byte_data  (byte_data),
        .byte_valid (byte_valid),
        .frame_err  (frame_err),
        .rec_valid  (rec_valid),
        .rec_ch     (rec_ch),
        .rec_neg    (rec_neg),
        .rec_bcd    (rec_bcd),
        .parse_err  (parse_err)
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Model: sent bytes in flight, position within the record template, latched and held fields.
    logic [7:0]  exp_bytes[$];
    int          fe_pending = 0;
    int          pos = 0;
    logic        m_ch = 1'b0, m_neg = 1'b0;
    logic [15:0] m_bcd = '0;
    logic        p_rv = 1'b0, p_pe = 1'b0, p_ch = 1'b0, p_neg = 1'b0;
    logic [15:0] p_bcd = '0;
    logic [7:0]  r_byte = '0;
    logic        r_ch = 1'b0, r_neg = 1'b0;
    logic [15:0] r_bcd = '0;
    logic        e_rv, e_pe;
    logic [7:0]  mon_b;
    bit          mon_en = 1'b0;
    int          n_bv = 0, n_fe = 0, n_rv = 0, n_pe = 0;
    logic [17:0] obs_rec[$];

    function automatic bit char_ok(input int p, input logic [7:0] b);
        case (p)
            1:          return b == "D";
            2:          return (b == "1") || (b == "2");
            3:          return b == ":";
            4:          return (b == "+") || (b == "-");
            5, 7, 8, 9: return (b >= "0") && (b <= "9");
            6:          return b == ".";
            10:         return b == "V";
            default:    return 1'b0;
        endcase
    endfunction

    task automatic model_byte(input logic [7:0] b);
        if (pos == 0) begin
            if (b == "A") pos = 1;
        end else if (char_ok(pos, b)) begin
            case (pos)
                2: m_ch = (b == "2");
                4: m_neg = (b == "-");
                5: m_bcd[15:12] = 4'(b - 8'd48);
                7: m_bcd[11:8]  = 4'(b - 8'd48);
                8: m_bcd[7:4]   = 4'(b - 8'd48);
                9: m_bcd[3:0]   = 4'(b - 8'd48);
                default: ;
            endcase
            if (pos == 10) begin
                p_rv = 1'b1; p_ch = m_ch; p_neg = m_neg; p_bcd = m_bcd;
                pos = 0;
            end else begin
                pos++;
            end
        end else begin
            p_pe = 1'b1;
            pos = (b == "A") ? 1 : 0;
        end
    endtask

    task automatic model_reset();
        exp_bytes.delete();
        fe_pending = 0; pos = 0;
        p_rv = 1'b0; p_pe = 1'b0;
        r_byte = '0; r_ch = 1'b0; r_neg = 1'b0; r_bcd = '0;
    endtask

    // Per-cycle compare of every output against the model.
    initial forever begin
        @(negedge clk);
        if (mon_en) begin
            e_rv = p_rv; e_pe = p_pe;
            p_rv = 1'b0; p_pe = 1'b0;
            if (e_rv) begin
                r_ch = p_ch; r_neg = p_neg; r_bcd = p_bcd;
            end
            if (byte_valid === 1'b1) begin
                n_bv++;
                check("byte_valid_expected", exp_bytes.size() > 0, 1);
                if (exp_bytes.size() > 0) begin
                    mon_b = exp_bytes.pop_front();
                    r_byte = mon_b;
                    model_byte(mon_b);
                end
            end
            if (frame_err === 1'b1) begin
                n_fe++;
                check("frame_err_expected", fe_pending > 0, 1);
                if (fe_pending > 0) fe_pending--;
                if (pos != 0) p_pe = 1'b1;
                pos = 0;
            end
            if (rec_valid === 1'b1) begin
                n_rv++;
                obs_rec.push_back({rec_ch, rec_neg, rec_bcd});
            end
            if (parse_err === 1'b1) n_pe++;
            check("byte_data", byte_data, r_byte);
            check("rec_valid", rec_valid, e_rv);
            check("parse_err", parse_err, e_pe);
            check("rec_ch", rec_ch, r_ch);
            check("rec_neg", rec_neg, r_neg);
            check("rec_bcd", rec_bcd, r_bcd);
            check("bv_fe_overlap", byte_valid & frame_err, 0);
        end
    end

    task automatic send_byte(input logic [7:0] b, input logic stop);
        if (stop) exp_bytes.push_back(b);
        else fe_pending++;
        rx = 1'b0;
        repeat (BIT_CLKS) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (BIT_CLKS) @(negedge clk);
        end
        rx = stop;
        repeat (BIT_CLKS) @(negedge clk);
        if (!stop) begin
            rx = 1'b1;
            repeat (BIT_CLKS) @(negedge clk);
        end
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i], 1'b1);
    endtask

    task automatic drain(input string name);
        repeat (8) @(negedge clk);
        check({name, "_bytes_left"}, exp_bytes.size(), 0);
        check({name, "_frames_left"}, fe_pending, 0);
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_byte_data"}, byte_data, 0);
        check({name, "_byte_valid"}, byte_valid, 0);
        check({name, "_frame_err"}, frame_err, 0);
        check({name, "_rec_valid"}, rec_valid, 0);
        check({name, "_rec_ch"}, rec_ch, 0);
        check({name, "_rec_neg"}, rec_neg, 0);
        check({name, "_rec_bcd"}, rec_bcd, 0);
        check({name, "_parse_err"}, parse_err, 0);
    endtask

    int bv0, fe0, rv0, pe0;
    task automatic snap();
        bv0 = n_bv; fe0 = n_fe; rv0 = n_rv; pe0 = n_pe;
        obs_rec.delete();
    endtask

    logic [7:0] rec_chars[11];
    int         kind, fe_at, glen;

    initial begin
        reset_n = 1'b0;
        rx = 1'b1;
        repeat (4) @(negedge clk);
        check_all_zero("reset");
        reset_n = 1'b1;
        mon_en = 1'b1;
        repeat (BIT_CLKS) @(negedge clk);

        // Single byte
        snap();
        send_byte(8'h55, 1'b1);
        drain("t1");
        check("t1_byte_data", byte_data, 8'h55);
        check("t1_bv_count", n_bv - bv0, 1);
        check("t1_fe_count", n_fe - fe0, 0);

        // Two records back to back with separators
        snap();
        send_str("AD1:+1.234V  AD2:-0.907V\n\r");
        drain("t2");
        check("t2_rec_count", n_rv - rv0, 2);
        check("t2_perr_count", n_pe - pe0, 0);
        if (obs_rec.size() >= 2) begin
            check("t2_rec0", obs_rec[0], 18'h01234);
            check("t2_rec1", obs_rec[1], 18'h30907);
        end
        check("t2_rec_bcd", rec_bcd, 16'h0907);

        // Stop bit forced low
        snap();
        send_byte(8'h41, 1'b0);
        drain("t3");
        check("t3_fe_count", n_fe - fe0, 1);
        check("t3_bv_count", n_bv - bv0, 0);
        check("t3_byte_data", byte_data, 8'h0D);

        // Bad channel digit, then a good record
        snap();
        send_str("AD3:+1.000V");
        drain("t4a");
        check("t4_perr_count", n_pe - pe0, 1);
        check("t4_rec_count", n_rv - rv0, 0);
        snap();
        send_str("AD2:+2.500V");
        drain("t4b");
        check("t4_rec_count2", n_rv - rv0, 1);
        if (obs_rec.size() >= 1) check("t4_rec", obs_rec[0], 18'h22500);

        // Resync on a stray 'A'
        snap();
        send_str("AD1:AD1:+0.001V");
        drain("t5");
        check("t5_perr_count", n_pe - pe0, 1);
        check("t5_rec_count", n_rv - rv0, 1);
        if (obs_rec.size() >= 1) check("t5_rec", obs_rec[0], 18'h00001);

        // Short low glitches are false starts
        snap();
        for (int g = 0; g < 3; g++) begin
            glen = (g == 0) ? 3 : $urandom_range(1, 6);
            rx = 1'b0;
            repeat (glen * BAUD_DIV) @(negedge clk);
            rx = 1'b1;
            repeat (2 * BIT_CLKS) @(negedge clk);
        end
        check("t6_glitch_bv", n_bv - bv0, 0);

        // Reset in the middle of the '1' of "AD1:+1"
        send_str("AD1:+");
        rx = 1'b0;
        repeat (BIT_CLKS) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rx = 1'(8'h31 >> i);
            repeat (BIT_CLKS) @(negedge clk);
        end
        mon_en = 1'b0;
        reset_n = 1'b0;
        rx = 1'b1;
        repeat (3) @(negedge clk);
        check_all_zero("mid_reset");
        model_reset();
        reset_n = 1'b1;
        mon_en = 1'b1;
        repeat (BIT_CLKS) @(negedge clk);
        snap();
        send_str("AD1:-9.876V");
        drain("t6");
        check("t6_rec_count", n_rv - rv0, 1);
        if (obs_rec.size() >= 1) check("t6_rec", obs_rec[0], 18'h19876);

        // Randomized records, corruptions and framing errors
        for (int r = 0; r < 3; r++) begin
            rec_chars[0] = "A";
            rec_chars[1] = "D";
            rec_chars[2] = ($urandom_range(0, 1) == 1) ? "2" : "1";
            rec_chars[3] = ":";
            rec_chars[4] = ($urandom_range(0, 1) == 1) ? "-" : "+";
            rec_chars[5] = 8'h30 + 8'($urandom_range(0, 9));
            rec_chars[6] = ".";
            for (int k = 7; k < 10; k++) rec_chars[k] = 8'h30 + 8'($urandom_range(0, 9));
            rec_chars[10] = "V";
            kind = $urandom_range(0, 2);
            fe_at = $urandom_range(1, 10);
            if (kind == 1) rec_chars[$urandom_range(1, 10)] = 8'($urandom_range(32, 90));
            for (int k = 0; k < 11; k++) begin
                if (kind == 2 && k == fe_at) send_byte(8'($urandom), 1'b0);
                send_byte(rec_chars[k], 1'b1);
            end
            if ($urandom_range(0, 1) == 1) send_byte(8'h20, 1'b1);
        end
        drain("rand");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
